// File: rtl/thermo_pkg.sv
// thermo_pkg: shared widths, entry count and FSM encoding for the thermo config responder.
package thermo_pkg;
    localparam int THERMO_ADDR_W  = 4;
    localparam int THERMO_DATA_W  = 20;
    localparam int THERMO_ENTRIES = 1 << THERMO_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LAT,
        S_RD_RSP,
        S_WR_RSP,
        S_CLEAR
    } state_t;
endpackage

// File: rtl/thermo_cfg_array.sv
// thermo_cfg_array: entry storage with per-entry valid bits and a saturating occupancy counter.
// Ports: clk, rst (async active-low); addr selects the entry for lookup, write and clear;
// wr_en/wr_data write the entry and set its valid bit; clr_en drops the valid bit;
// hit/data give the combinational lookup at addr; occupancy counts valid entries.
module thermo_cfg_array
    import thermo_pkg::*;
#(
    parameter int ADDR_W = THERMO_ADDR_W,
    parameter int DATA_W = THERMO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_en,
    output logic              hit,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W:0]   occupancy
);
    localparam int N = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(N);

    logic [DATA_W-1:0] mem_q [N];
    logic [N-1:0]      valid_q, valid_d;
    logic [ADDR_W:0]   occ_q, occ_d;

    assign hit       = valid_q[addr];
    assign data      = mem_q[addr];
    assign occupancy = occ_q;

    // Count only real transitions of a valid bit so rewrites and clears of empty slots leave occupancy alone.
    always_comb begin
        valid_d = valid_q;
        occ_d   = occ_q;
        if (wr_en) begin
            valid_d[addr] = 1'b1;
            occ_d = (!hit && occ_q != FULL) ? occ_q + 1'b1 : occ_q;
        end
        if (clr_en) begin
            valid_d[addr] = 1'b0;
            occ_d = (hit && occ_q != '0) ? occ_q - 1'b1 : occ_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Data contents need no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[addr] <= wr_data;
    end
endmodule

// File: rtl/thermo_cfg_responder.sv
// thermo_cfg_responder: request/response front end over a 16-entry config array with a clear sweep.
// Ports: clk, rst (async active-low); req_valid/req_we/req_addr/req_wdata with combinational
// req_ready; clear_req pulse starts an invalidate sweep; rsp_valid strobes hit_read/hit_write/rdata;
// busy flags the sweep; occupancy reports the number of valid entries.
module thermo_cfg_responder
    import thermo_pkg::*;
#(
    parameter int ADDR_W = THERMO_ADDR_W,
    parameter int DATA_W = THERMO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              clear_req,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              hit_read,
    output logic              hit_write,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W:0]   occupancy
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d, arr_addr;
    logic              clear_pending_q, clear_pending_d;
    logic              rsp_valid_q, rsp_valid_d, hit_read_q, hit_read_d, hit_write_q, hit_write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              accept, arr_hit;
    logic [DATA_W-1:0] arr_data;

    // rst gating keeps req_ready low while reset is held.
    assign req_ready = rst && state_q == S_IDLE && !clear_req && !clear_pending_q;
    assign accept    = req_valid && req_ready;
    assign arr_addr  = state_q == S_CLEAR ? cnt_q : state_q == S_IDLE ? req_addr : addr_q;

    assign rsp_valid = rsp_valid_q;
    assign hit_read  = hit_read_q;
    assign hit_write = hit_write_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;

    thermo_cfg_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk       (clk),
        .rst       (rst),
        .addr      (arr_addr),
        .wr_en     (accept && req_we),
        .wr_data   (req_wdata),
        .clr_en    (state_q == S_CLEAR),
        .hit       (arr_hit),
        .data      (arr_data),
        .occupancy (occupancy)
    );

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        clear_pending_d = clear_pending_q;
        rsp_valid_d     = 1'b0;
        hit_read_d      = 1'b0;
        hit_write_d     = 1'b0;
        rdata_d         = '0;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (accept) begin
                    addr_d      = req_addr;
                    state_d     = req_we ? S_WR_RSP : S_RD_LAT;
                    rsp_valid_d = req_we;
                    hit_write_d = req_we && arr_hit;
                end
            end
            S_RD_LAT: begin
                // Read data is captured here, so a clear arriving now cannot corrupt the response.
                clear_pending_d = clear_pending_q || clear_req;
                state_d         = S_RD_RSP;
                rsp_valid_d     = 1'b1;
                hit_read_d      = arr_hit;
                rdata_d         = arr_hit ? arr_data : '0;
            end
            S_RD_RSP, S_WR_RSP: begin
                state_d         = (clear_pending_q || clear_req) ? S_CLEAR : S_IDLE;
                clear_pending_d = 1'b0;
                cnt_d           = '0;
            end
            S_CLEAR: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = &cnt_q ? S_IDLE : S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d == S_CLEAR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            clear_pending_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            hit_read_q      <= 1'b0;
            hit_write_q     <= 1'b0;
            rdata_q         <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            clear_pending_q <= clear_pending_d;
            rsp_valid_q     <= rsp_valid_d;
            hit_read_q      <= hit_read_d;
            hit_write_q     <= hit_write_d;
            rdata_q         <= rdata_d;
            busy_q          <= busy_d;
        end
    end
endmodule

// File: tb/tb_thermo_cfg_responder.sv
// tb_thermo_cfg_responder: directed stimulus with a response scoreboard for thermo_cfg_responder.
module tb_thermo_cfg_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, clear_req = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [19:0] req_wdata = '0;
    logic        req_ready, rsp_valid, hit_read, hit_write, busy;
    logic [19:0] rdata;
    logic [4:0]  occupancy;

    typedef struct {
        logic        hr;
        logic        hw;
        logic [19:0] d;
        logic [4:0]  occ;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic        m_valid [16];
    logic [19:0] m_mem [16];
    logic [4:0]  m_occ = '0;

    thermo_cfg_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .clear_req (clear_req),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .hit_read  (hit_read),
        .hit_write (hit_write),
        .rdata     (rdata),
        .busy      (busy),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_occ = '0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rsp_valid) begin
                    if (q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
                    else begin
                        e = q.pop_front();
                        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                        chk("hit_read", 32'(hit_read), 32'(e.hr));
                        chk("hit_write", 32'(hit_write), 32'(e.hw));
                        chk("rdata", 32'(rdata), 32'(e.d));
                        chk("rsp_occupancy", 32'(occupancy), 32'(e.occ));
                    end
                end else chk("quiet_outputs", {11'd0, hit_read, hit_write, rdata}, 0);
            end
        end
    end

    task automatic issue(input logic we, input logic [3:0] a, input logic [19:0] d, input bit clr_lat);
        exp_t e;
        int   k;
        @(posedge clk);
        #1 req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 1);
            req_valid = 1'b0;
            return;
        end
        e.cyc = cyc + (we ? 1 : 2);
        e.hr  = !we && m_valid[a];
        e.hw  = we && m_valid[a];
        e.d   = (!we && m_valid[a]) ? m_mem[a] : 20'd0;
        if (we) begin
            if (!m_valid[a]) m_occ = m_occ + 1'b1;
            m_valid[a] = 1'b1;
            m_mem[a]   = d;
        end
        e.occ = m_occ;
        q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (clr_lat) begin
            clear_req = 1'b1;
            @(posedge clk);
            #1 clear_req = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", 32'(q.size()), 0);
    endtask

    // Optionally pulses clear_req, then measures the sweep; a second clear mid-sweep must not restart it.
    task automatic sweep(input bit pulse);
        int k = 0, n = 0;
        if (pulse) begin
            @(posedge clk);
            #1 clear_req = 1'b1;
            @(posedge clk);
            #1 clear_req = 1'b0;
        end
        @(negedge clk);
        while (!busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        while (busy && n < 100) begin
            n++;
            chk("ready_in_clear", 32'(req_ready), 0);
            if (n == 5) clear_req = 1'b1;
            if (n == 6) clear_req = 1'b0;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 16);
        chk("occ_after_clear", 32'(occupancy), 0);
        chk("ready_after_clear", 32'(req_ready), 1);
        model_clear();
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {14'd0, req_ready, rsp_valid, hit_read, hit_write, busy, 8'd0, occupancy}, 0);
        chk("reset_rdata", 32'(rdata), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 1);

        issue(1'b0, 4'd3, 20'd0, 1'b0);
        drain();
        issue(1'b1, 4'd3, 20'h0A5A5, 1'b0);
        issue(1'b0, 4'd3, 20'd0, 1'b0);
        issue(1'b1, 4'd3, 20'h00010, 1'b0);
        issue(1'b0, 4'd3, 20'd0, 1'b0);
        drain();

        for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 20'(i * 32'h1111 + 7), 1'b0);
        drain();
        chk("occ_full", 32'(occupancy), 16);
        sweep(1'b1);
        issue(1'b0, 4'd0, 20'd0, 1'b0);
        issue(1'b0, 4'd15, 20'd0, 1'b0);
        drain();

        issue(1'b1, 4'd5, 20'h12345, 1'b0);
        issue(1'b0, 4'd5, 20'd0, 1'b1);
        sweep(1'b0);
        drain();
        issue(1'b0, 4'd5, 20'd0, 1'b0);
        drain();

        issue(1'b1, 4'd1, 20'h00111, 1'b0);
        issue(1'b1, 4'd2, 20'h00222, 1'b0);
        drain();
        @(posedge clk);
        #1 clear_req = 1'b1;
        @(posedge clk);
        #1 clear_req = 1'b0;
        @(negedge clk);
        chk("busy_before_reset", 32'(busy), 1);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_outputs", {14'd0, req_ready, rsp_valid, hit_read, hit_write, busy, 8'd0, occupancy}, 0);
        chk("rst_rdata", 32'(rdata), 0);
        q.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst_release", 32'(req_ready), 1);
        chk("busy_after_rst_release", 32'(busy), 0);
        issue(1'b0, 4'd1, 20'd0, 1'b0);
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
